// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared types and helpers for the MEM pipeline stage.
//               - Access-size encodings SZ_B/SZ_H/SZ_W (mem_size[1:0]).
//               - Stage FSM state enum (IDLE/WAIT).
//               - Byte-enable, store-lane and alignment helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // Effective byte offset once the low address bits are forced to the natural
  // alignment of the access size.
  function automatic logic [1:0] align_off(input logic [1:0] size, input logic [1:0] a);
    logic [1:0] r;
    case (size)
      SZ_B:    r = a;
      SZ_H:    r = {a[1], 1'b0};
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // Byte enables; half/word ignore the low bits that would misalign them.
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] a);
    logic [3:0] r;
    case (size)
      SZ_B:    r = 4'b0001 << a;
      SZ_H:    r = 4'b0011 << {a[1], 1'b0};
      default: r = 4'hF;
    endcase
    return r;
  endfunction

  // Store data is right-aligned; replicate it into every lane so the byte
  // enables alone select where it lands.
  function automatic logic [31:0] wdata_gen(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      SZ_B:    r = {4{d[7:0]}};
      SZ_H:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    logic r;
    case (size)
      SZ_B:    r = 1'b0;
      SZ_H:    r = a[0];
      default: r = (a != 2'b00);
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage_if
// Description : Data-memory request/acknowledge bus of the MEM stage.
//               master : the MEM stage (drives request, write data, enables)
//               slave  : the data memory (drives ack and read data)
//               dm_req/dm_we/dm_addr/dm_be/dm_wdata : request side
//               dm_ack/dm_rdata                     : response side
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_access_stage_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [3:0]    dm_be;
  logic [DW-1:0] dm_wdata;
  logic          dm_ack;
  logic [DW-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
    output dm_ack, dm_rdata
  );

endinterface
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_load_align
// Description : Combinational load formatter. Shifts the read word right by
//               8*off_i and sign- or zero-extends the selected byte/half.
//   rdata_i [DW-1:0] raw memory read data
//   off_i   [1:0]    byte offset (already aligned to the access size)
//   size_i  [2:0]    [1:0] size, [2] 1=zero-extend 0=sign-extend
//   data_o  [DW-1:0] formatted load value
// Revision    : 1.0 - initial release
// ============================================================================
module mem_load_align
  import mem_stage_pkg::*;
#(
  parameter int DW = 32
) (
  input  wire logic [DW-1:0] rdata_i,
  input  wire logic [1:0]    off_i,
  input  wire logic [2:0]    size_i,
  output logic      [DW-1:0] data_o
);

  logic [DW-1:0] w_shifted;
  logic          w_sext;

  assign w_shifted = rdata_i >> {off_i, 3'b000};
  assign w_sext    = ~size_i[2];

  always_comb begin
    data_o = w_shifted;
    case (size_i[1:0])
      SZ_B:    data_o = {{(DW-8){w_sext & w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    data_o = {{(DW-16){w_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: data_o = w_shifted;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : MEM pipeline stage between EX_MEM and MEM_WB. Non-memory ops
//               pass through with one-cycle latency; loads/stores are issued
//               on the dm bus and the upstream pipe is stalled until dm_ack.
//               Results are presented with a one-cycle enableMEM strobe.
//   reloj, reset_n           clock / async active-low reset
//   ex_valid, mem_rd, mem_wr instruction valid, load, store
//   mem_size[2:0]            access size + zero-extend flag
//   alu_res, st_data         address/ALU value, right-aligned store data
//   ctrl_WB_ex, Y_MUX_ex     writeback control / destination (pass-through)
//   stall_o                  freeze EX_MEM and earlier
//   dm (master modport)      data-memory req/ack bus
//   enableMEM, ctrl_WB_mem, DO, DIR, Y_MUX_mem   results to MEM_WB
//   misalign_o               misaligned-access trap flag
// Build option: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
//               accesses instead of silently aligning them.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  wire logic          reloj,
  input  wire logic          reset_n,
  input  wire logic          ex_valid,
  input  wire logic          mem_rd,
  input  wire logic          mem_wr,
  input  wire logic [2:0]    mem_size,
  input  wire logic [DW-1:0] alu_res,
  input  wire logic [DW-1:0] st_data,
  input  wire logic [1:0]    ctrl_WB_ex,
  input  wire logic [4:0]    Y_MUX_ex,
  output logic               stall_o,
  mem_access_stage_if.master dm,
  output logic               enableMEM,
  output logic      [1:0]    ctrl_WB_mem,
  output logic      [DW-1:0] DO,
  output logic      [DW-1:0] DIR,
  output logic      [4:0]    Y_MUX_mem,
  output logic               misalign_o
);

  state_e state_q, state_d;

  logic w_is_mem;
  logic w_trap;
  logic w_idle;
  logic w_accept_mem;
  logic w_accept_pass;
  logic w_complete;
  logic w_req;
  logic w_stall;

  // Request captured at accept; held stable for the whole WAIT period.
  logic          lat_rd_q;
  logic          lat_we_q;
  logic [2:0]    lat_size_q;
  logic [1:0]    lat_off_q;
  logic [AW-1:0] lat_addr_q;
  logic [3:0]    lat_be_q;
  logic [DW-1:0] lat_wdata_q;
  logic [1:0]    lat_ctrl_q;
  logic [4:0]    lat_y_q;
  logic [DW-1:0] lat_dir_q;

  // Result registers towards MEM_WB.
  logic          en_q, en_d;
  logic          mis_q, mis_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [DW-1:0] do_q, do_d;
  logic [DW-1:0] dir_q, dir_d;
  logic [4:0]    y_q, y_d;

  logic [DW-1:0] w_load_data;

  assign w_is_mem = mem_rd | mem_wr;
  assign w_idle   = (state_q == IDLE);

`ifdef MEM_MISALIGN_TRAP_EN
  assign w_trap = w_is_mem & misaligned(mem_size[1:0], alu_res[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  // A trapped access never reaches memory; it completes like a pass-through.
  assign w_accept_mem  = w_idle & ex_valid & w_is_mem & ~w_trap;
  assign w_accept_pass = w_idle & ex_valid & (~w_is_mem | w_trap);
  assign w_complete    = (state_q == WAIT) & dm.dm_ack;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (w_accept_mem) state_d = WAIT;
    end else begin
      if (dm.dm_ack) state_d = IDLE;
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    if (state_q == IDLE) begin
      w_stall = w_accept_mem;
    end else begin
      w_req   = 1'b1;
      // The ack cycle releases the pipe so EX_MEM advances on the same edge
      // that completes the access.
      w_stall = ~dm.dm_ack;
    end
  end

  // Gated by reset so a held ex_valid cannot raise stall while in reset.
  assign stall_o     = w_stall & reset_n;
  assign dm.dm_req   = w_req;
  assign dm.dm_we    = lat_we_q;
  assign dm.dm_addr  = lat_addr_q;
  assign dm.dm_be    = lat_be_q;
  assign dm.dm_wdata = lat_wdata_q;

  // ---------------- Request latch ----------------
  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      lat_rd_q    <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_size_q  <= 3'b000;
      lat_off_q   <= 2'b00;
      lat_addr_q  <= '0;
      lat_be_q    <= 4'b0000;
      lat_wdata_q <= '0;
      lat_ctrl_q  <= 2'b00;
      lat_y_q     <= 5'd0;
      lat_dir_q   <= '0;
    end else if (w_accept_mem) begin
      lat_rd_q    <= mem_rd;
      lat_we_q    <= mem_wr;
      lat_size_q  <= mem_size;
      lat_off_q   <= align_off(mem_size[1:0], alu_res[1:0]);
      lat_addr_q  <= {alu_res[AW-1:2], 2'b00};
      lat_be_q    <= be_gen(mem_size[1:0], alu_res[1:0]);
      lat_wdata_q <= wdata_gen(mem_size[1:0], st_data);
      lat_ctrl_q  <= ctrl_WB_ex;
      lat_y_q     <= Y_MUX_ex;
      lat_dir_q   <= alu_res;
    end
  end

  mem_load_align #(
    .DW (DW)
  ) u_load_align (
    .rdata_i (dm.dm_rdata),
    .off_i   (lat_off_q),
    .size_i  (lat_size_q),
    .data_o  (w_load_data)
  );

  // ---------------- Result next-state ----------------
  always_comb begin
    en_d   = w_accept_pass | w_complete;
    mis_d  = w_accept_pass & w_trap;
    ctrl_d = ctrl_q;
    do_d   = do_q;
    dir_d  = dir_q;
    y_d    = y_q;
    if (w_accept_pass) begin
      // A trapped access must not write the register file.
      ctrl_d = w_trap ? 2'b00 : ctrl_WB_ex;
      do_d   = '0;
      dir_d  = alu_res;
      y_d    = Y_MUX_ex;
    end else if (w_complete) begin
      ctrl_d = lat_ctrl_q;
      do_d   = lat_rd_q ? w_load_data : '0;
      dir_d  = lat_dir_q;
      y_d    = lat_y_q;
    end
  end

  always_ff @(posedge reloj or negedge reset_n) begin
    if (!reset_n) begin
      en_q   <= 1'b0;
      mis_q  <= 1'b0;
      ctrl_q <= 2'b00;
      do_q   <= '0;
      dir_q  <= '0;
      y_q    <= 5'd0;
    end else begin
      en_q   <= en_d;
      mis_q  <= mis_d;
      ctrl_q <= ctrl_d;
      do_q   <= do_d;
      dir_q  <= dir_d;
      y_q    <= y_d;
    end
  end

  assign enableMEM   = en_q;
  assign misalign_o  = mis_q;
  assign ctrl_WB_mem = ctrl_q;
  assign DO          = do_q;
  assign DIR         = dir_q;
  assign Y_MUX_mem   = y_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. Directed scenarios
//               followed by random loads/stores/ALU ops, each compared with
//               an arithmetic reference of the stage's load/store rules.
//               Honours MEM_MISALIGN_TRAP_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        reloj = 1'b0;
  logic        reset_n;
  logic        ex_valid;
  logic        mem_rd;
  logic        mem_wr;
  logic [2:0]  mem_size;
  logic [31:0] alu_res;
  logic [31:0] st_data;
  logic [1:0]  ctrl_WB_ex;
  logic [4:0]  Y_MUX_ex;
  logic        stall_o;
  logic        enableMEM;
  logic [1:0]  ctrl_WB_mem;
  logic [31:0] DO;
  logic [31:0] DIR;
  logic [4:0]  Y_MUX_mem;
  logic        misalign_o;

  int total = 0;
  int bad   = 0;

  mem_access_stage_if #(.AW(32), .DW(32)) mem_if ();

  mem_access_stage #(.AW(32), .DW(32)) dut (
    .reloj       (reloj),
    .reset_n     (reset_n),
    .ex_valid    (ex_valid),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .alu_res     (alu_res),
    .st_data     (st_data),
    .ctrl_WB_ex  (ctrl_WB_ex),
    .Y_MUX_ex    (Y_MUX_ex),
    .stall_o     (stall_o),
    .dm          (mem_if),
    .enableMEM   (enableMEM),
    .ctrl_WB_mem (ctrl_WB_mem),
    .DO          (DO),
    .DIR         (DIR),
    .Y_MUX_mem   (Y_MUX_mem),
    .misalign_o  (misalign_o)
  );

  always #5 reloj = ~reloj;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // One instruction through the stage; expectations come from the access rules.
  task automatic run_op(input logic rd, input logic wr, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] st,
                        input logic [31:0] rdat, input logic [1:0] ctl,
                        input logic [4:0] y, input int delay);
    logic        is_mem, trap, misal;
    int unsigned off, eoff, szc;
    logic [31:0] exp_be, exp_wd, exp_do, v;
    int          stall_cnt;
    is_mem = rd | wr;
    szc    = sz[1:0];
    off    = a % 4;
    misal  = (szc == 1 && (off % 2) == 1) || (szc == 2 && off != 0);
`ifdef MEM_MISALIGN_TRAP_EN
    trap = is_mem & misal;
`else
    trap = 1'b0;
`endif
    eoff   = (szc == 0) ? off : (szc == 1) ? (off / 2) * 2 : 0;
    exp_be = (szc == 0) ? (32'd1 << eoff) : (szc == 1) ? (32'd3 << eoff) : 32'hF;
    exp_wd = (szc == 0) ? (st & 32'hFF) * 32'h0101_0101
           : (szc == 1) ? (st & 32'hFFFF) * 32'h0001_0001 : st;
    v = rdat >> (8 * eoff);
    if (szc == 0) begin
      exp_do = v & 32'hFF;
      if (!sz[2] && exp_do >= 32'd128) exp_do = exp_do + 32'hFFFF_FF00;
    end else if (szc == 1) begin
      exp_do = v & 32'hFFFF;
      if (!sz[2] && exp_do >= 32'd32768) exp_do = exp_do + 32'hFFFF_0000;
    end else begin
      exp_do = v;
    end
    if (!rd) exp_do = 32'd0;

    @(negedge reloj);
    ex_valid = 1'b1; mem_rd = rd; mem_wr = wr; mem_size = sz;
    alu_res = a; st_data = st; ctrl_WB_ex = ctl; Y_MUX_ex = y;
    #1;
    chk("stall_accept", {31'd0, stall_o}, {31'd0, is_mem & ~trap});
    chk("req_accept", {31'd0, mem_if.dm_req}, 32'd0);
    if (!is_mem || trap) begin
      @(negedge reloj);
      ex_valid = 1'b0;
      chk("pass_en", {31'd0, enableMEM}, 32'd1);
      chk("pass_dir", DIR, a);
      chk("pass_do", DO, 32'd0);
      chk("pass_y", {27'd0, Y_MUX_mem}, {27'd0, y});
      chk("pass_ctrl", {30'd0, ctrl_WB_mem}, trap ? 32'd0 : {30'd0, ctl});
      chk("pass_mis", {31'd0, misalign_o}, {31'd0, trap});
      chk("pass_noreq", {31'd0, mem_if.dm_req}, 32'd0);
      @(negedge reloj);
      chk("pass_en_off", {31'd0, enableMEM}, 32'd0);
      chk("pass_mis_off", {31'd0, misalign_o}, 32'd0);
    end else begin
      stall_cnt = 1;
      for (int i = 0; i <= delay; i++) begin
        @(negedge reloj);
        if (i == delay) begin
          mem_if.dm_ack = 1'b1;
          mem_if.dm_rdata = rdat;
        end else begin
          mem_if.dm_rdata = $urandom;
        end
        #1;
        chk("wait_req", {31'd0, mem_if.dm_req}, 32'd1);
        chk("wait_we", {31'd0, mem_if.dm_we}, {31'd0, wr});
        chk("wait_addr", mem_if.dm_addr, a & 32'hFFFF_FFFC);
        chk("wait_be", {28'd0, mem_if.dm_be}, exp_be);
        chk("wait_wdata", mem_if.dm_wdata, exp_wd);
        chk("wait_en", {31'd0, enableMEM}, 32'd0);
        chk("wait_stall", {31'd0, stall_o}, (i == delay) ? 32'd0 : 32'd1);
        if (stall_o) stall_cnt++;
      end
      chk("stall_cycles", stall_cnt, 1 + delay);
      @(negedge reloj);
      mem_if.dm_ack = 1'b0;
      mem_if.dm_rdata = $urandom;
      ex_valid = 1'b0;
      chk("done_en", {31'd0, enableMEM}, 32'd1);
      chk("done_do", DO, exp_do);
      chk("done_dir", DIR, a);
      chk("done_y", {27'd0, Y_MUX_mem}, {27'd0, y});
      chk("done_ctrl", {30'd0, ctrl_WB_mem}, {30'd0, ctl});
      chk("done_req", {31'd0, mem_if.dm_req}, 32'd0);
      chk("done_mis", {31'd0, misalign_o}, 32'd0);
      @(negedge reloj);
      chk("done_en_off", {31'd0, enableMEM}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] hold_dir;
    int          kind;
    reset_n = 1'b0; ex_valid = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    mem_size = 3'd0; alu_res = 32'd0; st_data = 32'd0;
    ctrl_WB_ex = 2'd0; Y_MUX_ex = 5'd0;
    mem_if.dm_ack = 1'b0; mem_if.dm_rdata = 32'd0;

    // Reset state
    repeat (3) @(negedge reloj);
    chk("rst_stall", {31'd0, stall_o}, 32'd0);
    chk("rst_req", {31'd0, mem_if.dm_req}, 32'd0);
    chk("rst_we", {31'd0, mem_if.dm_we}, 32'd0);
    chk("rst_addr", mem_if.dm_addr, 32'd0);
    chk("rst_be", {28'd0, mem_if.dm_be}, 32'd0);
    chk("rst_wdata", mem_if.dm_wdata, 32'd0);
    chk("rst_en", {31'd0, enableMEM}, 32'd0);
    chk("rst_ctrl", {30'd0, ctrl_WB_mem}, 32'd0);
    chk("rst_do", DO, 32'd0);
    chk("rst_dir", DIR, 32'd0);
    chk("rst_y", {27'd0, Y_MUX_mem}, 32'd0);
    chk("rst_mis", {31'd0, misalign_o}, 32'd0);
    reset_n = 1'b1;

    // 1: non-memory op
    run_op(1'b0, 1'b0, 3'b010, 32'h0000_1234, 32'd0, 32'd0, 2'b11, 5'd7, 0);

    // Stray ack while idle is ignored; outputs hold
    @(negedge reloj);
    mem_if.dm_ack = 1'b1; mem_if.dm_rdata = 32'hDEAD_BEEF;
    @(negedge reloj);
    mem_if.dm_ack = 1'b0;
    chk("stray_en", {31'd0, enableMEM}, 32'd0);
    chk("stray_dir", DIR, 32'h0000_1234);
    chk("stray_req", {31'd0, mem_if.dm_req}, 32'd0);

    // 2: LB a=0x103, ack after 3 WAIT cycles
    run_op(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_FF12, 2'b01, 5'd3, 3);
    // 3: SH a=0x102
    run_op(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'h1111_1111, 2'b00, 5'd0, 1);
    // 4: LHU a=0x100, immediate ack
    run_op(1'b1, 1'b0, 3'b101, 32'h0000_0100, 32'd0, 32'h0000_8001, 2'b01, 5'd9, 0);
    // 5: LW a=0x102 (traps or aligns depending on build)
    run_op(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'd0, 32'hCAFE_F00D, 2'b01, 5'd12, 1);

    // 6: reset asserted in the second WAIT cycle
    @(negedge reloj);
    ex_valid = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; mem_size = 3'b010;
    alu_res = 32'h0000_0204; ctrl_WB_ex = 2'b01; Y_MUX_ex = 5'd4;
    hold_dir = DIR;
    @(negedge reloj);
    @(negedge reloj);
    chk("r6_req_before", {31'd0, mem_if.dm_req}, 32'd1);
    ex_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("r6_req", {31'd0, mem_if.dm_req}, 32'd0);
    chk("r6_stall", {31'd0, stall_o}, 32'd0);
    chk("r6_en", {31'd0, enableMEM}, 32'd0);
    @(negedge reloj);
    chk("r6_en_hold", {31'd0, enableMEM}, 32'd0);
    chk("r6_dir_clr", DIR, (hold_dir & 32'd0));
    reset_n = 1'b1;
    @(negedge reloj);
    chk("r6_req_after", {31'd0, mem_if.dm_req}, 32'd0);
    chk("r6_en_after", {31'd0, enableMEM}, 32'd0);
    run_op(1'b0, 1'b0, 3'b000, 32'h0000_5678, 32'd0, 32'd0, 2'b10, 5'd21, 0);

    // Random traffic
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      run_op(kind == 1, kind == 2,
             {1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))},
             $urandom, $urandom, $urandom,
             2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
             $urandom_range(0, 3));
    end

    repeat (2) @(negedge reloj);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
